// File: rtl/mem_dump.sv
// -----------------------------------------------------------------------------
// mem_dump -- walks an inclusive, wrapping address range of the byte-wide
// memory and streams each byte out over a valid/ready interface. The memory
// bus is only driven after a request/grant handshake with the bus arbiter.
//
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append one extra byte, the
// 8-bit additive checksum of all dumped bytes, after the last data byte.
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset_n     in   asynchronous active-low reset
//   start       in   begin a dump (sampled only while idle)
//   start_addr  in   [7:0] first address, latched on accepted start
//   end_addr    in   [7:0] last address (inclusive), latched on accepted start
//   bus_req     out  memory bus request
//   bus_grant   in   arbiter grant; our memory signals reach mem while high
//   mem_clock   out  one-cycle memory read strobe
//   mem_write   out  always 0
//   address     out  [7:0] memory address
//   to_mem      out  [7:0] always 0x00
//   from_mem    in   [7:0] memory read data
//   out_data    out  [7:0] streamed byte
//   out_valid   out  out_data is valid
//   out_ready   in   downstream accepts the byte
//   busy        out  high whenever not idle
//   done        out  one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module mem_dump (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [7:0] end_addr,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic       mem_clock,
  output logic       mem_write,
  output logic [7:0] address,
  output logic [7:0] to_mem,
  input  logic [7:0] from_mem,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_STROBE,
    S_SAMPLE,
    S_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [7:0] cur;       // address currently being read
  logic [7:0] last;      // latched inclusive end address
  logic [7:0] data_q;    // byte captured from memory
  logic       req_seen;  // bus_req has already been driven for a full cycle
  logic       last_byte;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign last_byte = (cur == last);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others; blocking = here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so every path assigns it;
  // a missing assignment in combinational logic would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_REQ;
      // A grant is only acted on once our request has been visible for a full
      // cycle, so a grant level left over from another master is not mistaken
      // for the answer to this request.
      S_REQ:    if (bus_grant && req_seen) next_state = S_ADDR;
      // Losing the grant anywhere in the read phase retries the same address.
      S_ADDR:   next_state = bus_grant ? S_STROBE : S_REQ;
      S_STROBE: next_state = bus_grant ? S_SAMPLE : S_REQ;
      S_SAMPLE: next_state = bus_grant ? S_SEND   : S_REQ;
      S_SEND: begin
        if (out_ready) begin
          if (last_byte) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            next_state = S_CSUM;
`else
            next_state = S_DONE;
`endif
          end else begin
            next_state = S_ADDR;
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM:   if (out_ready) next_state = S_DONE;
`endif
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= 8'h00;
      last     <= 8'h00;
      data_q   <= 8'h00;
      req_seen <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      // Clears on every entry into REQ, including re-entry after grant loss.
      req_seen <= (state == S_REQ);

      if (state == S_IDLE && start) begin
        cur  <= start_addr;
        last <= end_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum <= 8'h00;
`endif
      end

      // Only capture while we still own the bus; otherwise the data belongs
      // to another master and the address is retried anyway.
      if (state == S_SAMPLE && bus_grant) begin
        data_q <= from_mem;
      end

      // Advance only on an accepted transfer; cur stays on the end address
      // after the last byte. The checksum accumulates accepted bytes, so a
      // retried read is never counted twice.
      if (state == S_SEND && out_ready) begin
        if (!last_byte) begin
          cur <= cur + 8'd1;
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        csum <= csum + data_q;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  assign mem_write = 1'b0;
  assign to_mem    = 8'h00;
  // cur only moves on an accepted transfer, so the address is stable across
  // ADDR, STROBE and SAMPLE around the strobe.
  assign address   = cur;

  always_comb begin
    bus_req   = 1'b0;
    mem_clock = 1'b0;
    out_valid = 1'b0;
    out_data  = data_q;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_REQ:    bus_req = 1'b1;
      S_ADDR:   bus_req = 1'b1;
      S_STROBE: begin
        bus_req   = 1'b1;
        // Decoded from the state register; gating with the grant drops the
        // strobe the moment the bus is taken away.
        mem_clock = bus_grant;
      end
      S_SAMPLE: bus_req = 1'b1;
      S_SEND: begin
        bus_req   = 1'b1;
        out_valid = 1'b1;
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM: begin
        bus_req   = 1'b1;
        out_valid = 1'b1;
        out_data  = csum;
      end
`endif
      S_DONE:   done = 1'b1;
      default: begin
        bus_req   = 1'b0;
        mem_clock = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule
